bus_timer: RTL

Memory-mapped 8-bit timer peripheral and interrupt source for the system bus. It is the responder on the processor's shared bus: it decodes BUS_ADDR, captures writes on BUS_WE and drives BUS_DATA on reads. It is also the raising side of the interrupt handshake, asserting BUS_INTERRUPT_RAISE and holding it until the processor returns BUS_INTERRUPT_ACK. The top level wires it to interrupt line 1 of the processor's 2-bit interrupt bus.

---
 rtl/bus_timer.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/bus_timer.sv
// bus_timer: memory-mapped 8-bit timer and level interrupt source on the shared processor bus.
// Define BUS_TIMER_READBACK_EN to make the registers readable; otherwise the block is write-only.
module bus_timer #(
  parameter logic [7:0]  BASE_ADDR = 8'hF0,
  parameter logic [23:0] PRESCALE  = 24'd100000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] BUS_ADDR,
  input  logic       BUS_WE,
  inout  wire  [7:0] BUS_DATA,
  output logic       BUS_INTERRUPT_RAISE,
  input  logic       BUS_INTERRUPT_ACK
);

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PERIOD = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_RAISED = 1'b1
  } irq_state_t;

  logic        w_hit;
  logic        w_wr;
  logic        w_wr_ctrl;
  logic        w_wr_period;
  logic        w_wr_count;
  logic        w_wr_status;
  logic [7:0]  w_wdata;

  logic        r_en;
  logic        r_irq_en;
  logic        r_auto;
  logic [7:0]  r_period;
  logic [7:0]  r_count;
  logic        r_pending;
  logic        r_overrun;
  logic [23:0] r_pre;

  logic        w_tick;
  logic        w_event;
  logic        w_irq_event;

  logic [23:0] w_pre_next;
  logic        w_en_next;
  logic        w_irq_en_next;
  logic        w_auto_next;
  logic [7:0]  w_period_next;
  logic [7:0]  w_count_next;
  logic        w_pending_next;
  logic        w_overrun_next;

  irq_state_t  r_state;
  irq_state_t  w_state_next;
  logic        w_raise;
  logic        w_overrun_set;

  assign w_hit       = (BUS_ADDR[7:2] == BASE_ADDR[7:2]);
  assign w_wr        = w_hit & BUS_WE;
  assign w_wr_ctrl   = w_wr & (BUS_ADDR[1:0] == ADDR_CTRL);
  assign w_wr_period = w_wr & (BUS_ADDR[1:0] == ADDR_PERIOD);
  assign w_wr_count  = w_wr & (BUS_ADDR[1:0] == ADDR_COUNT);
  assign w_wr_status = w_wr & (BUS_ADDR[1:0] == ADDR_STATUS);
  assign w_wdata     = BUS_DATA;

  assign w_tick      = r_en & (r_pre == (PRESCALE - 24'd1));
  assign w_event     = w_tick & (r_count == r_period);
  assign w_irq_event = w_event & r_irq_en;

  always_comb begin
    w_pre_next = r_pre;
    if (!r_en || w_wr_ctrl || w_tick) begin
      w_pre_next = 24'd0;
    end else begin
      w_pre_next = r_pre + 24'd1;
    end
  end

  // Bus writes take priority over every internal update in the same cycle.
  always_comb begin
    w_en_next     = r_en;
    w_irq_en_next = r_irq_en;
    w_auto_next   = r_auto;
    if (w_wr_ctrl) begin
      w_en_next     = w_wdata[0];
      w_irq_en_next = w_wdata[1];
      w_auto_next   = w_wdata[2];
    end else if (w_event && !r_auto) begin
      w_en_next = 1'b0;
    end else begin
      w_en_next = r_en;
    end
  end

  always_comb begin
    w_period_next = r_period;
    if (w_wr_period) begin
      w_period_next = w_wdata;
    end else begin
      w_period_next = r_period;
    end
  end

  always_comb begin
    w_count_next = r_count;
    if (w_wr_count) begin
      w_count_next = w_wdata;
    end else if (w_event) begin
      w_count_next = 8'd0;
    end else if (w_tick) begin
      w_count_next = r_count + 8'd1;
    end else begin
      w_count_next = r_count;
    end
  end

  always_comb begin
    w_pending_next = r_pending | w_event;
    w_overrun_next = r_overrun | w_overrun_set;
    if (w_wr_status && w_wdata[0]) begin
      w_pending_next = 1'b0;
    end else begin
      w_pending_next = r_pending | w_event;
    end
    if (w_wr_status && w_wdata[1]) begin
      w_overrun_next = 1'b0;
    end else begin
      w_overrun_next = r_overrun | w_overrun_set;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_pre     <= 24'd0;
      r_en      <= 1'b0;
      r_irq_en  <= 1'b0;
      r_auto    <= 1'b0;
      r_period  <= 8'd0;
      r_count   <= 8'd0;
      r_pending <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_pre     <= w_pre_next;
      r_en      <= w_en_next;
      r_irq_en  <= w_irq_en_next;
      r_auto    <= w_auto_next;
      r_period  <= w_period_next;
      r_count   <= w_count_next;
      r_pending <= w_pending_next;
      r_overrun <= w_overrun_next;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // An acknowledge that coincides with a fresh event keeps the request up.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_irq_event) begin
          w_state_next = ST_RAISED;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_RAISED: begin
        if (BUS_INTERRUPT_ACK && !w_irq_event) begin
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_RAISED;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_raise       = 1'b0;
    w_overrun_set = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_raise       = 1'b0;
        w_overrun_set = 1'b0;
      end
      ST_RAISED: begin
        w_raise       = 1'b1;
        w_overrun_set = w_irq_event & ~BUS_INTERRUPT_ACK;
      end
      default: begin
        w_raise       = 1'b0;
        w_overrun_set = 1'b0;
      end
    endcase
  end

  assign BUS_INTERRUPT_RAISE = w_raise;

`ifdef BUS_TIMER_READBACK_EN
  logic       w_rd;
  logic [7:0] w_rd_mux;
  logic [7:0] r_rd_data;
  logic       r_rd_oe;

  assign w_rd = w_hit & ~BUS_WE;

  always_comb begin
    w_rd_mux = 8'h00;
    case (BUS_ADDR[1:0])
      ADDR_CTRL:   w_rd_mux = {5'd0, r_auto, r_irq_en, r_en};
      ADDR_PERIOD: w_rd_mux = r_period;
      ADDR_COUNT:  w_rd_mux = r_count;
      ADDR_STATUS: w_rd_mux = {6'd0, r_overrun, r_pending};
      default:     w_rd_mux = 8'h00;
    endcase
  end

  // Read data is captured at the addressing edge and driven for exactly one cycle.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_rd_oe   <= 1'b0;
      r_rd_data <= 8'h00;
    end else begin
      r_rd_oe <= w_rd;
      if (w_rd) begin
        r_rd_data <= w_rd_mux;
      end else begin
        r_rd_data <= r_rd_data;
      end
    end
  end

  assign BUS_DATA = r_rd_oe ? r_rd_data : 8'hzz;
`else
  assign BUS_DATA = 8'hzz;
`endif

endmodule
